// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the RV32I multicycle controller.
// Optional perf counters in mc_controller are enabled by the PERF_CNT_EN macro.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_JAL,
        S_BRANCH,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Coarse ALU request from the FSM; FUNCT defers to the instruction fields.
    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       adrsrc;
        logic       regwrite;
        logic       pcwrite;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] result;
        aluop_t     aluop;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = ctrl_t'('0);
        case (s)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.srca    = SRCA_PC;
                c.srcb    = SRCB_4;
                c.result  = RES_ALURESULT;
                c.aluop   = ALUOP_ADD;
            end
            S_DECODE: begin
                c.srca  = SRCA_OLDPC;
                c.srcb  = SRCB_IMM;
                c.aluop = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.srca  = SRCA_RD1;
                c.srcb  = SRCB_IMM;
                c.aluop = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adrsrc  = 1'b1;
            end
            S_MEMWB: begin
                c.result   = RES_DATA;
                c.regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req  = 1'b1;
                c.memwrite = 1'b1;
                c.adrsrc   = 1'b1;
            end
            S_EXEC_R: begin
                c.srca  = SRCA_RD1;
                c.srcb  = SRCB_RD2;
                c.aluop = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                c.srca  = SRCA_RD1;
                c.srcb  = SRCB_IMM;
                c.aluop = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result   = RES_ALUOUT;
                c.regwrite = 1'b1;
            end
            S_JAL: begin
                c.srca    = SRCA_OLDPC;
                c.srcb    = SRCB_4;
                c.aluop   = ALUOP_ADD;
                c.result  = RES_ALUOUT;
                c.pcwrite = 1'b1;
            end
            S_BRANCH: begin
                c.srca   = SRCA_RD1;
                c.srcb   = SRCB_RD2;
                c.aluop  = ALUOP_SUB;
                c.result = RES_ALUOUT;
            end
            default: c = ctrl_t'('0);
        endcase
        return c;
    endfunction

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Memory request/ready handshake between the controller and the memory port.
interface mc_controller_if;
    logic mem_req;
    logic MemWrite;
    logic AdrSrc;
    logic mem_ready;

    modport master (
        output mem_req,
        output MemWrite,
        output AdrSrc,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  MemWrite,
        input  AdrSrc,
        output mem_ready
    );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// ALU operation decode from the coarse FSM request and instruction fields.
module alu_decoder
    import mc_controller_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  aluop_t     alu_op,
    output logic [3:0] ALUControl
);

    logic is_rtype;
    assign is_rtype = (op == OP_R);

    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'd0:    ALUControl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'd1:    ALUControl = ALU_SLL;
                    3'd2:    ALUControl = ALU_SLT;
                    3'd3:    ALUControl = ALU_SLTU;
                    3'd4:    ALUControl = ALU_XOR;
                    3'd5:    ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'd6:    ALUControl = ALU_OR;
                    default: ALUControl = ALU_AND;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: Fetch, Decode, Execute/Mem/Writeback.
// Define PERF_CNT_EN to build the cycle/instret counters; otherwise they read 0.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mc_controller_if.master   mem,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              Zero,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic              RegWrite,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ImmSrc,
    output logic [3:0]        ALUControl,
    output logic              illegal,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
);

    state_t state;
    state_t nxt;
    ctrl_t  ctrl_q;
    logic   illegal_q;

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:    if (mem.mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_R:              nxt = S_EXEC_R;
                    OP_I:              nxt = S_EXEC_I;
                    OP_JAL:            nxt = S_JAL;
                    OP_BRANCH:         nxt = (funct3 == 3'b000 || funct3 == 3'b001)
                                             ? S_BRANCH : S_TRAP;
                    default:           nxt = S_TRAP;
                endcase
            end
            S_MEMADR:   nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem.mem_ready) nxt = S_MEMWB;
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWRITE: if (mem.mem_ready) nxt = S_FETCH;
            S_EXEC_R:   nxt = S_ALUWB;
            S_EXEC_I:   nxt = S_ALUWB;
            S_ALUWB:    nxt = S_FETCH;
            S_JAL:      nxt = S_ALUWB;
            S_BRANCH:   nxt = S_FETCH;
            S_TRAP:     nxt = S_TRAP;
            default:    nxt = S_FETCH;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            ctrl_q    <= state_ctrl(S_FETCH);
            illegal_q <= 1'b0;
        end else begin
            state  <= nxt;
            ctrl_q <= state_ctrl(nxt);
            if (nxt == S_TRAP)
                illegal_q <= 1'b1;
        end
    end

    // Enables are gated by the async reset so an in-flight request drops at once.
    assign mem.mem_req  = reset & ctrl_q.mem_req;
    assign mem.MemWrite = reset & ctrl_q.memwrite;
    assign mem.AdrSrc   = ctrl_q.adrsrc;
    assign RegWrite     = reset & ctrl_q.regwrite;
    assign IRWrite      = reset & (state == S_FETCH) & mem.mem_ready;
    assign PCWrite      = reset & (((state == S_FETCH) & mem.mem_ready)
                                   | ctrl_q.pcwrite
                                   | ((state == S_BRANCH) & (Zero ^ funct3[0])));
    assign ALUSrcA      = ctrl_q.srca;
    assign ALUSrcB      = ctrl_q.srcb;
    assign ResultSrc    = ctrl_q.result;
    assign ImmSrc       = imm_sel(op);
    assign illegal      = illegal_q;

    alu_decoder u_alu_decoder (
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alu_op     (ctrl_q.aluop),
        .ALUControl (ALUControl)
    );

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ret_q;
    logic             retire;

    assign retire = (nxt == S_FETCH) &&
                    (state == S_MEMWB || state == S_MEMWRITE ||
                     state == S_ALUWB || state == S_BRANCH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else if (state != S_TRAP) begin
            cyc_q <= cyc_q + 1'b1;
            if (retire)
                ret_q <= ret_q + 1'b1;
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed table-driven bench for mc_controller plus multi-cycle corner sequences.
module tb_mc_controller;

    localparam logic [6:0] OPR = 7'h33;
    localparam logic [6:0] OPI = 7'h13;
    localparam logic [6:0] OPL = 7'h03;
    localparam logic [6:0] OPS = 7'h23;
    localparam logic [6:0] OPB = 7'h63;
    localparam logic [6:0] OPJ = 7'h6F;
    localparam logic [6:0] OPX = 7'h7F;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       IRWrite, PCWrite, RegWrite, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [3:0] ALUControl;
    logic [3:0] cycle_cnt, instret_cnt;

    mc_controller_if mif ();

    mc_controller #(.CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem         (mif),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .Zero        (Zero),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ResultSrc   (ResultSrc),
        .ImmSrc      (ImmSrc),
        .ALUControl  (ALUControl),
        .illegal     (illegal),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];

    // Expected-output packing: {mem_req,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,SrcA,SrcB,Result,Imm,ALUCtl,illegal}
    function automatic logic [18:0] ex(input bit mr, mw, ad, ir, pc, rw,
                                       input int a, b, r, im, alu, input bit il);
        logic [1:0] a2, b2, r2, i2;
        logic [3:0] al;
        a2 = a[1:0]; b2 = b[1:0]; r2 = r[1:0]; i2 = im[1:0]; al = alu[3:0];
        return {mr, mw, ad, ir, pc, rw, a2, b2, r2, i2, al, il};
    endfunction

    function automatic vec_t mk(input string n, input logic [6:0] o, input logic [2:0] f3,
                                input logic f7, input logic z, input logic rdy,
                                input logic [18:0] e);
        vec_t v;
        v.name = n; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy; v.exp = e;
        return v;
    endfunction

    function automatic logic [18:0] sample();
        return {mif.mem_req, mif.MemWrite, mif.AdrSrc, IRWrite, PCWrite, RegWrite,
                ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal};
    endfunction

    task automatic check(input string nm, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z; mif.mem_ready = v.rdy;
        #1;
        check(v.name, sample(), v.exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mif.mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; op = OPR; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
        mif.mem_ready = 1'b1;

        // add, sub, srai, addi(bit30 set), sltiu
        tbl.push_back(mk("add_F",   OPR, 0, 0, 0, 1, ex(1,0,0,1,1,0, 0,2,2,0,0,0)));
        tbl.push_back(mk("add_D",   OPR, 0, 0, 0, 1, ex(0,0,0,0,0,0, 1,1,0,0,0,0)));
        tbl.push_back(mk("add_EX",  OPR, 0, 0, 0, 0, ex(0,0,0,0,0,0, 2,0,0,0,0,0)));
        tbl.push_back(mk("add_WB",  OPR, 0, 0, 0, 0, ex(0,0,0,0,0,1, 0,0,0,0,0,0)));
        tbl.push_back(mk("sub_Fw",  OPR, 0, 1, 0, 0, ex(1,0,0,0,0,0, 0,2,2,0,0,0)));
        tbl.push_back(mk("sub_F",   OPR, 0, 1, 0, 1, ex(1,0,0,1,1,0, 0,2,2,0,0,0)));
        tbl.push_back(mk("sub_D",   OPR, 0, 1, 0, 0, ex(0,0,0,0,0,0, 1,1,0,0,0,0)));
        tbl.push_back(mk("sub_EX",  OPR, 0, 1, 0, 0, ex(0,0,0,0,0,0, 2,0,0,0,1,0)));
        tbl.push_back(mk("sub_WB",  OPR, 0, 1, 0, 0, ex(0,0,0,0,0,1, 0,0,0,0,0,0)));
        tbl.push_back(mk("srai_F",  OPI, 5, 1, 0, 1, ex(1,0,0,1,1,0, 0,2,2,0,0,0)));
        tbl.push_back(mk("srai_D",  OPI, 5, 1, 0, 0, ex(0,0,0,0,0,0, 1,1,0,0,0,0)));
        tbl.push_back(mk("srai_EX", OPI, 5, 1, 0, 0, ex(0,0,0,0,0,0, 2,1,0,0,8,0)));
        tbl.push_back(mk("srai_WB", OPI, 5, 1, 0, 0, ex(0,0,0,0,0,1, 0,0,0,0,0,0)));
        tbl.push_back(mk("addi_F",  OPI, 0, 1, 0, 1, ex(1,0,0,1,1,0, 0,2,2,0,0,0)));
        tbl.push_back(mk("addi_D",  OPI, 0, 1, 0, 0, ex(0,0,0,0,0,0, 1,1,0,0,0,0)));
        tbl.push_back(mk("addi_EX", OPI, 0, 1, 0, 0, ex(0,0,0,0,0,0, 2,1,0,0,0,0)));
        tbl.push_back(mk("addi_WB", OPI, 0, 1, 0, 0, ex(0,0,0,0,0,1, 0,0,0,0,0,0)));
        tbl.push_back(mk("sltiu_F", OPI, 3, 0, 0, 1, ex(1,0,0,1,1,0, 0,2,2,0,0,0)));
        tbl.push_back(mk("sltiu_D", OPI, 3, 0, 0, 0, ex(0,0,0,0,0,0, 1,1,0,0,0,0)));
        tbl.push_back(mk("sltiu_EX",OPI, 3, 0, 0, 0, ex(0,0,0,0,0,0, 2,1,0,0,9,0)));
        tbl.push_back(mk("sltiu_WB",OPI, 3, 0, 0, 0, ex(0,0,0,0,0,1, 0,0,0,0,0,0)));
        // lw with three wait cycles in MEMREAD
        tbl.push_back(mk("lw_F",    OPL, 2, 0, 0, 1, ex(1,0,0,1,1,0, 0,2,2,0,0,0)));
        tbl.push_back(mk("lw_D",    OPL, 2, 0, 0, 0, ex(0,0,0,0,0,0, 1,1,0,0,0,0)));
        tbl.push_back(mk("lw_ADR",  OPL, 2, 0, 0, 1, ex(0,0,0,0,0,0, 2,1,0,0,0,0)));
        tbl.push_back(mk("lw_RD0",  OPL, 2, 0, 0, 0, ex(1,0,1,0,0,0, 0,0,0,0,0,0)));
        tbl.push_back(mk("lw_RD1",  OPL, 2, 0, 0, 0, ex(1,0,1,0,0,0, 0,0,0,0,0,0)));
        tbl.push_back(mk("lw_RD2",  OPL, 2, 0, 0, 0, ex(1,0,1,0,0,0, 0,0,0,0,0,0)));
        tbl.push_back(mk("lw_RD3",  OPL, 2, 0, 0, 1, ex(1,0,1,0,0,0, 0,0,0,0,0,0)));
        tbl.push_back(mk("lw_WB",   OPL, 2, 0, 0, 1, ex(0,0,0,0,0,1, 0,0,1,0,0,0)));
        // sw, no wait
        tbl.push_back(mk("sw_F",    OPS, 2, 0, 0, 1, ex(1,0,0,1,1,0, 0,2,2,1,0,0)));
        tbl.push_back(mk("sw_D",    OPS, 2, 0, 0, 0, ex(0,0,0,0,0,0, 1,1,0,1,0,0)));
        tbl.push_back(mk("sw_ADR",  OPS, 2, 0, 0, 0, ex(0,0,0,0,0,0, 2,1,0,1,0,0)));
        tbl.push_back(mk("sw_WR",   OPS, 2, 0, 0, 1, ex(1,1,1,0,0,0, 0,0,0,1,0,0)));
        // branches: bne/beq with both Zero values
        tbl.push_back(mk("bne0_F",  OPB, 1, 0, 0, 1, ex(1,0,0,1,1,0, 0,2,2,2,0,0)));
        tbl.push_back(mk("bne0_D",  OPB, 1, 0, 0, 0, ex(0,0,0,0,0,0, 1,1,0,2,0,0)));
        tbl.push_back(mk("bne0_BR", OPB, 1, 0, 0, 0, ex(0,0,0,0,1,0, 2,0,0,2,1,0)));
        tbl.push_back(mk("beq0_F",  OPB, 0, 0, 0, 1, ex(1,0,0,1,1,0, 0,2,2,2,0,0)));
        tbl.push_back(mk("beq0_D",  OPB, 0, 0, 0, 0, ex(0,0,0,0,0,0, 1,1,0,2,0,0)));
        tbl.push_back(mk("beq0_BR", OPB, 0, 0, 0, 0, ex(0,0,0,0,0,0, 2,0,0,2,1,0)));
        tbl.push_back(mk("beq1_F",  OPB, 0, 0, 1, 1, ex(1,0,0,1,1,0, 0,2,2,2,0,0)));
        tbl.push_back(mk("beq1_D",  OPB, 0, 0, 1, 0, ex(0,0,0,0,0,0, 1,1,0,2,0,0)));
        tbl.push_back(mk("beq1_BR", OPB, 0, 0, 1, 0, ex(0,0,0,0,1,0, 2,0,0,2,1,0)));
        tbl.push_back(mk("bne1_F",  OPB, 1, 0, 1, 1, ex(1,0,0,1,1,0, 0,2,2,2,0,0)));
        tbl.push_back(mk("bne1_D",  OPB, 1, 0, 1, 0, ex(0,0,0,0,0,0, 1,1,0,2,0,0)));
        tbl.push_back(mk("bne1_BR", OPB, 1, 0, 1, 0, ex(0,0,0,0,0,0, 2,0,0,2,1,0)));
        // jal
        tbl.push_back(mk("jal_F",   OPJ, 0, 0, 0, 1, ex(1,0,0,1,1,0, 0,2,2,3,0,0)));
        tbl.push_back(mk("jal_D",   OPJ, 0, 0, 0, 0, ex(0,0,0,0,0,0, 1,1,0,3,0,0)));
        tbl.push_back(mk("jal_J",   OPJ, 0, 0, 0, 0, ex(0,0,0,0,1,0, 1,2,0,3,0,0)));
        tbl.push_back(mk("jal_WB",  OPJ, 0, 0, 0, 0, ex(0,0,0,0,0,1, 0,0,0,3,0,0)));
        tbl.push_back(mk("post_F",  OPR, 0, 0, 0, 0, ex(1,0,0,0,0,0, 0,2,2,0,0,0)));

        // Reset state with mem_ready high: enables forced low, FETCH selects
        @(negedge clk); @(negedge clk);
        #1;
        check("reset_state", sample(), ex(0,0,0,0,0,0, 0,2,2,0,0,0));
        check("reset_cnt", {cycle_cnt, instret_cnt}, '0);
        @(negedge clk);
        mif.mem_ready = 1'b0;
        reset = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Unsupported opcode traps and stays trapped
        apply(mk("x_F", OPX, 0, 0, 0, 1, ex(1,0,0,1,1,0, 0,2,2,0,0,0)));
        apply(mk("x_D", OPX, 0, 0, 0, 1, ex(0,0,0,0,0,0, 1,1,0,0,0,0)));
        for (int i = 0; i < 20; i++)
            apply(mk("trap_hold", OPX, 1, 1, 1, 1, ex(0,0,0,0,0,0, 0,0,0,0,0,1)));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("trap_reset", sample(), ex(0,0,0,0,0,0, 0,2,2,0,0,0));
        @(negedge clk);
        reset = 1'b1;
        mif.mem_ready = 1'b0;
        #1;
        check("trap_rel", sample(), ex(1,0,0,0,0,0, 0,2,2,0,0,0));

        // Branch with unsupported funct3 also traps
        apply(mk("bx_F",  OPB, 2, 0, 0, 1, ex(1,0,0,1,1,0, 0,2,2,2,0,0)));
        apply(mk("bx_D",  OPB, 2, 0, 0, 0, ex(0,0,0,0,0,0, 1,1,0,2,0,0)));
        apply(mk("bx_T",  OPB, 2, 0, 1, 1, ex(0,0,0,0,0,0, 0,0,0,2,0,1)));
        do_reset();

        // Reset during a stalled store drops the request immediately
        apply(mk("rs_F",   OPS, 2, 0, 0, 1, ex(1,0,0,1,1,0, 0,2,2,1,0,0)));
        apply(mk("rs_D",   OPS, 2, 0, 0, 0, ex(0,0,0,0,0,0, 1,1,0,1,0,0)));
        apply(mk("rs_ADR", OPS, 2, 0, 0, 0, ex(0,0,0,0,0,0, 2,1,0,1,0,0)));
        apply(mk("rs_WR",  OPS, 2, 0, 0, 0, ex(1,1,1,0,0,0, 0,0,0,1,0,0)));
        #2;
        reset = 1'b0;
        #1;
        check("rs_drop", sample(), ex(0,0,0,0,0,0, 0,2,2,1,0,0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rs_rel", sample(), ex(1,0,0,0,0,0, 0,2,2,1,0,0));
        apply(mk("rs_F2", OPS, 2, 0, 0, 1, ex(1,0,0,1,1,0, 0,2,2,1,0,0)));

`ifdef PERF_CNT_EN
        @(negedge clk);
        reset = 1'b0;
        mif.mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("cnt_rel", {cycle_cnt, instret_cnt}, {4'd0, 4'd0});
        for (int k = 0; k < 3; k++) begin
            apply(mk("c_F",  OPR, 0, 0, 0, 1, ex(1,0,0,1,1,0, 0,2,2,0,0,0)));
            apply(mk("c_D",  OPR, 0, 0, 0, 0, ex(0,0,0,0,0,0, 1,1,0,0,0,0)));
            apply(mk("c_EX", OPR, 0, 0, 0, 0, ex(0,0,0,0,0,0, 2,0,0,0,0,0)));
            apply(mk("c_WB", OPR, 0, 0, 0, 0, ex(0,0,0,0,0,1, 0,0,0,0,0,0)));
        end
        check("cnt_12", {cycle_cnt, instret_cnt}, {4'd12, 4'd2});
        apply(mk("c_Fw", OPR, 0, 0, 0, 0, ex(1,0,0,0,0,0, 0,2,2,0,0,0)));
        check("cnt_13", {cycle_cnt, instret_cnt}, {4'd13, 4'd3});
        for (int k = 0; k < 3; k++)
            apply(mk("c_Fw", OPR, 0, 0, 0, 0, ex(1,0,0,0,0,0, 0,2,2,0,0,0)));
        check("cnt_wrap", {cycle_cnt, instret_cnt}, {4'd0, 4'd3});
        apply(mk("c_xF", OPX, 0, 0, 0, 1, ex(1,0,0,1,1,0, 0,2,2,0,0,0)));
        apply(mk("c_xD", OPX, 0, 0, 0, 0, ex(0,0,0,0,0,0, 1,1,0,0,0,0)));
        apply(mk("c_xT", OPX, 0, 0, 0, 0, ex(0,0,0,0,0,0, 0,0,0,0,0,1)));
        check("cnt_trap", {cycle_cnt, instret_cnt}, {4'd3, 4'd3});
        apply(mk("c_xT2", OPX, 0, 0, 0, 0, ex(0,0,0,0,0,0, 0,0,0,0,0,1)));
        check("cnt_frozen", {cycle_cnt, instret_cnt}, {4'd3, 4'd3});
`else
        check("cnt_tied", {cycle_cnt, instret_cnt}, '0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
